// File: rtl/ram_responder_if.sv
// Request/response bundle between the cache control unit (master) and the
// RAM responder (slave).
interface ram_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              ram_avalid;
  logic              ram_rnw;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ack;
  logic              busy;
  logic [15:0]       rd_count;
  logic [15:0]       wr_count;

  modport master (
    output ram_avalid, ram_rnw, ram_addr, ram_wdata,
    input  ram_rdata, ram_ack, busy, rd_count, wr_count
  );

  modport slave (
    input  ram_avalid, ram_rnw, ram_addr, ram_wdata,
    output ram_rdata, ram_ack, busy, rd_count, wr_count
  );
endinterface

// File: rtl/ram_responder.sv
// Fixed-latency single-port RAM model answering cache requests with a one-cycle ack.
// Optional completed-access counters are enabled by defining RAM_RESPONDER_STATS_EN.
module ram_responder #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 4
) (
  input  logic           clk,
  input  logic           not_reset,
  ram_responder_if.slave bus
);
  localparam int         DEPTH    = 2 ** ADDR_W;
  localparam logic [7:0] LAT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    ACK    = 2'b10
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [7:0]        cnt_r;
  logic [7:0]        cnt_s;
  logic              accept_s;
  logic              commit_s;
  logic              ack_r;
  logic              busy_r;
  logic              rnw_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] rdata_r;
  logic [DATA_W-1:0] mem_r [DEPTH];

  // Next-state and latency-counter logic; a drop of ram_avalid during ACCESS aborts.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    accept_s = 1'b0;
    commit_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.ram_avalid) begin
          state_s  = ACCESS;
          cnt_s    = LAT_LOAD;
          accept_s = 1'b1;
        end else begin
          state_s  = IDLE;
        end
      end
      ACCESS: begin
        if (!bus.ram_avalid) begin
          state_s = IDLE;
          cnt_s   = 8'd0;
        end else if (cnt_r == 8'd0) begin
          state_s  = ACK;
          commit_s = 1'b1;
        end else begin
          cnt_s = cnt_r - 8'd1;
        end
      end
      ACK: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 8'd0;
      end
    endcase
  end

  // State, counter and the registered ack/busy strobes decoded from the next state.
  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      state_r <= IDLE;
      cnt_r   <= 8'd0;
      ack_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      ack_r   <= (state_s == ACK);
      busy_r  <= (state_s == ACCESS);
    end
  end

  // Request fields are captured only at acceptance so later bus changes are ignored.
  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      rnw_r   <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
    end else if (accept_s) begin
      rnw_r   <= bus.ram_rnw;
      addr_r  <= bus.ram_addr;
      wdata_r <= bus.ram_wdata;
    end
  end

  // Read data holds until the next completed read.
  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      rdata_r <= '0;
    end else if (commit_s && rnw_r) begin
      rdata_r <= mem_r[addr_r];
    end
  end

  // Storage array deliberately has no reset so contents survive not_reset.
  always_ff @(posedge clk) begin
    if (commit_s && !rnw_r) begin
      mem_r[addr_r] <= wdata_r;
    end
  end

`ifdef RAM_RESPONDER_STATS_EN
  logic [15:0] rd_count_r;
  logic [15:0] wr_count_r;

  // Completed-access counters, wrapping naturally at 16 bits.
  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      rd_count_r <= 16'h0000;
      wr_count_r <= 16'h0000;
    end else if (commit_s) begin
      if (rnw_r) begin
        rd_count_r <= rd_count_r + 16'd1;
      end else begin
        wr_count_r <= wr_count_r + 16'd1;
      end
    end
  end

  assign bus.rd_count = rd_count_r;
  assign bus.wr_count = wr_count_r;
`else
  assign bus.rd_count = 16'h0000;
  assign bus.wr_count = 16'h0000;
`endif

  assign bus.ram_rdata = rdata_r;
  assign bus.ram_ack   = ack_r;
  assign bus.busy      = busy_r;
endmodule
